conv_seq_ctrl: RTL and testbench
================================

# conv_seq_ctrl

Top-level sequencer for the 1-D convolution engine. Accepts filter and input-vector streams over valid/ready handshakes, generates write strobes and addresses for the filter memory (fmem) and input memory (xmem), then raises `conv_start` to run the convolution control and MAC datapath until `conv_done`, and loops for the next vector. It sits between the AXI-stream input ports and the memory/convolution-control blocks.

## Interface
Parameters:
- F_MEM_SIZE, 4, filter taps (≥2)
- X_MEM_SIZE, 8, input vector length (≥F_MEM_SIZE)
- F_MEM_ADDR_WIDTH, 2, fmem address width (2^W ≥ F_MEM_SIZE)
- X_MEM_ADDR_WIDTH, 3, xmem address width (2^W ≥ X_MEM_SIZE)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- seq_en  in  1  level; permits leaving IDLE
- s_valid_f  in  1  filter word valid
- s_ready_f  out  1  filter word ready
- s_valid_x  in  1  input word valid
- s_ready_x  out  1  input word ready
- reuse_filter  in  1  sampled on conv_done; request to keep the current filter (see Configuration)
- fmem_wr_en  out  1  fmem write strobe
- fmem_wr_addr  out  F_MEM_ADDR_WIDTH  fmem write address
- xmem_wr_en  out  1  xmem write strobe
- xmem_wr_addr  out  X_MEM_ADDR_WIDTH  xmem write address
- conv_start  out  1  level; high for the whole convolution run
- conv_done  in  1  one-cycle pulse from convolution control
- busy  out  1  state ≠ IDLE
- conv_count  out  16  completed convolutions, wraps at 2^16

## Operation
- States: IDLE, LOAD_F, LOAD_X, CONV.
- IDLE: all outputs low. seq_en=1 → LOAD_F.
- LOAD_F: s_ready_f=1. Each beat with s_valid_f&s_ready_f asserts fmem_wr_en with fmem_wr_addr=f_cnt and increments f_cnt. When the accepted beat has f_cnt=F_MEM_SIZE-1, f_cnt→0 and the state → LOAD_X.
- LOAD_X: the same as LOAD_F, using s_ready_x, xmem_wr_en and x_cnt up to X_MEM_SIZE-1, then → CONV.
- CONV: conv_start=1 and both readies low. conv_done=1 → conv_count+1 and the next state is chosen as follows:
  - LOAD_X if FILTER_REUSE_EN is defined and reuse_filter=1;
  - otherwise LOAD_F.
  - seq_en=0 at conv_done → IDLE; this takes priority.
- conv_done outside CONV: ignored, no count.
- s_ready_f and s_ready_x are never high together. Readies are combinational from the state only, never from valid.
- Write strobes are combinational: `valid & ready` in the same cycle. Addresses are held as registered counters.
- seq_en dropping in LOAD_F or LOAD_X does not abort the load. It is only checked in IDLE and at conv_done.

## Timing
- Reset values: state=IDLE, f_cnt=x_cnt=0, conv_count=0. All 1-bit outputs are 0 and all address outputs are 0.
- IDLE→LOAD_F: s_ready_f is high one cycle after seq_en is sampled high.
- Last beat accepted in cycle N: the next ready (or conv_start) is high in N+1. There are no bubble cycles.
- conv_done in cycle M: conv_start is low in M+1. The next load ready is high in M+1. conv_count updates at M+1.
- Minimum loop with continuous valids: F_MEM_SIZE + X_MEM_SIZE cycles of load, plus the convolution length.
- Reset mid-operation: everything returns to reset values on the next edge. Partial memory contents are abandoned.
- Valid held low mid-load: counters hold and no strobe is issued.

## Configuration
- FILTER_REUSE_EN defined: reuse_filter=1 at conv_done skips LOAD_F. The filter stays in fmem and only the new X vector is loaded.
- FILTER_REUSE_EN undefined: reuse_filter is ignored and every run reloads the filter. The port remains present.

## Structure
- Package conv_seq_pkg holds:
  - the state enum type conv_seq_state_t (2-bit encoding);
  - the constant CONV_COUNT_WIDTH=16.
- Sub-module seq_load_cnt (parameters SIZE, WIDTH) is instantiated twice, once for f_cnt and once for x_cnt.
  - Inputs: clk, reset, en, valid.
  - Outputs: addr, wr_en, last.
  - The counter wraps to 0 on last.

## Test plan
- Reset, then seq_en=1 with continuous valids:
  - 4 fmem writes to addresses 0..3 in consecutive cycles;
  - then 8 xmem writes to addresses 0..7;
  - conv_start rises the cycle after xmem address 7.
- Gapped valids (s_valid_x toggling every other cycle) → exactly 8 xmem writes, addresses incrementing only on accepted beats, and no write while valid=0.
- conv_done pulse with reuse_filter=1 under FILTER_REUSE_EN:
  - next cycle conv_start=0, s_ready_x=1, s_ready_f=0;
  - conv_count=1.
  - Without the macro, s_ready_f=1 instead.
- Spurious conv_done during LOAD_X → state and conv_count unchanged, and x_cnt keeps counting.
- seq_en=0 at conv_done → IDLE with busy=0. Reassert seq_en → LOAD_F resumes at address 0.
- reset asserted mid-LOAD_X at x_cnt=5 → next cycle all outputs are 0 and state is IDLE. A restart writes fmem from address 0.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared types and constants for the convolution sequencer
package conv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_F = 2'd1,
        ST_LOAD_X = 2'd2,
        ST_CONV   = 2'd3
    } conv_seq_state_t;

    localparam int CONV_COUNT_WIDTH = 16;

endpackage

// File: rtl/seq_load_cnt.sv
// rtl/seq_load_cnt.sv - write-address counter and strobe for one memory load stream
module seq_load_cnt #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             valid,
    output logic [WIDTH-1:0] addr,
    output logic             wr_en,
    output logic             last
);

    logic [WIDTH-1:0] cnt;

    assign wr_en = en & valid;
    assign last  = wr_en && (cnt == WIDTH'(SIZE - 1));
    assign addr  = cnt;

    // Advance only on accepted beats; wrap to 0 after the final word so the next load starts clean
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (wr_en) begin
            if (last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - load/convolve sequencer; FILTER_REUSE_EN enables filter reuse
module conv_seq_ctrl
    import conv_seq_pkg::*;
#(
    parameter int F_MEM_SIZE       = 4,
    parameter int X_MEM_SIZE       = 8,
    parameter int F_MEM_ADDR_WIDTH = 2,
    parameter int X_MEM_ADDR_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        seq_en,
    input  logic                        s_valid_f,
    output logic                        s_ready_f,
    input  logic                        s_valid_x,
    output logic                        s_ready_x,
    input  logic                        reuse_filter,
    output logic                        fmem_wr_en,
    output logic [F_MEM_ADDR_WIDTH-1:0] fmem_wr_addr,
    output logic                        xmem_wr_en,
    output logic [X_MEM_ADDR_WIDTH-1:0] xmem_wr_addr,
    output logic                        conv_start,
    input  logic                        conv_done,
    output logic                        busy,
    output logic [CONV_COUNT_WIDTH-1:0] conv_count
);

`ifdef FILTER_REUSE_EN
    localparam bit REUSE_EN = 1'b1;
`else
    localparam bit REUSE_EN = 1'b0;
`endif

    conv_seq_state_t state, next_state;
    logic            f_last, x_last, done_hit;

    seq_load_cnt #(
        .SIZE  (F_MEM_SIZE),
        .WIDTH (F_MEM_ADDR_WIDTH)
    ) u_f_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (s_ready_f),
        .valid (s_valid_f),
        .addr  (fmem_wr_addr),
        .wr_en (fmem_wr_en),
        .last  (f_last)
    );

    seq_load_cnt #(
        .SIZE  (X_MEM_SIZE),
        .WIDTH (X_MEM_ADDR_WIDTH)
    ) u_x_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (s_ready_x),
        .valid (s_valid_x),
        .addr  (xmem_wr_addr),
        .wr_en (xmem_wr_en),
        .last  (x_last)
    );

    // conv_done only counts while a convolution is actually running
    assign done_hit = conv_start & conv_done;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Completed-convolution counter, wraps naturally at its width
    always_ff @(posedge clk) begin
        if (reset) begin
            conv_count <= '0;
        end else if (done_hit) begin
            conv_count <= conv_count + 1'b1;
        end
    end

    // Next state and state-decoded outputs; readies depend on state only, never on valid
    always_comb begin
        next_state = state;
        s_ready_f  = 1'b0;
        s_ready_x  = 1'b0;
        conv_start = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (seq_en) next_state = ST_LOAD_F;
            end
            ST_LOAD_F: begin
                s_ready_f = 1'b1;
                if (f_last) next_state = ST_LOAD_X;
            end
            ST_LOAD_X: begin
                s_ready_x = 1'b1;
                if (x_last) next_state = ST_CONV;
            end
            ST_CONV: begin
                conv_start = 1'b1;
                if (conv_done) begin
                    if (!seq_en) begin
                        next_state = ST_IDLE;
                    end else if (REUSE_EN && reuse_filter) begin
                        next_state = ST_LOAD_X;
                    end else begin
                        next_state = ST_LOAD_F;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - directed self-checking bench for conv_seq_ctrl
module tb_conv_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, seq_en, s_valid_f, s_valid_x, reuse_filter, conv_done;
    logic        s_ready_f, s_ready_x, fmem_wr_en, xmem_wr_en, conv_start, busy;
    logic [1:0]  fmem_wr_addr;
    logic [2:0]  xmem_wr_addr;
    logic [15:0] conv_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_seq_ctrl #(
        .F_MEM_SIZE       (4),
        .X_MEM_SIZE       (8),
        .F_MEM_ADDR_WIDTH (2),
        .X_MEM_ADDR_WIDTH (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .seq_en       (seq_en),
        .s_valid_f    (s_valid_f),
        .s_ready_f    (s_ready_f),
        .s_valid_x    (s_valid_x),
        .s_ready_x    (s_ready_x),
        .reuse_filter (reuse_filter),
        .fmem_wr_en   (fmem_wr_en),
        .fmem_wr_addr (fmem_wr_addr),
        .xmem_wr_en   (xmem_wr_en),
        .xmem_wr_addr (xmem_wr_addr),
        .conv_start   (conv_start),
        .conv_done    (conv_done),
        .busy         (busy),
        .conv_count   (conv_count)
    );

    typedef struct packed {
        logic        rf;
        logic        rx;
        logic        fwe;
        logic [1:0]  fa;
        logic        xwe;
        logic [2:0]  xa;
        logic        st;
        logic        bz;
        logic [15:0] cnt;
    } outs_t;

    typedef struct {
        logic  se, vf, vx, cd, ru;
        outs_t o;
    } vec_t;

    vec_t tbl[$];

    function automatic outs_t cur();
        return {s_ready_f, s_ready_x, fmem_wr_en, fmem_wr_addr, xmem_wr_en,
                xmem_wr_addr, conv_start, busy, conv_count};
    endfunction

    function automatic outs_t mko(logic rf, logic rx, logic fwe, logic [1:0] fa, logic xwe,
                                  logic [2:0] xa, logic st, logic bz, logic [15:0] cnt);
        return {rf, rx, fwe, fa, xwe, xa, st, bz, cnt};
    endfunction

    function automatic void add(logic se, logic vf, logic vx, logic cd, logic ru, outs_t o);
        vec_t v;
        v.se = se; v.vf = vf; v.vx = vx; v.cd = cd; v.ru = ru; v.o = o;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic se, input logic vf, input logic vx, input logic cd, input logic ru);
        seq_en = se; s_valid_f = vf; s_valid_x = vx; conv_done = cd; reuse_filter = ru;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset_state", 32'(cur()), 32'(mko(0,0,0,0,0,0,0,0,0)));
        reset = 1'b0;
    endtask

    task automatic load_f_full(input logic [15:0] cnt, input string tag);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0);
            chk({tag, "_fload"}, 32'(cur()), 32'(mko(1,0,1,2'(i),0,0,0,1,cnt)));
            tick();
        end
    endtask

    initial begin
        int wr_seen;

        // Main flow table: one row per cycle, outputs checked before the edge
        add(1,0,0,0,0, mko(0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 4; i++) add(1,1,0,0,0, mko(1,0,1,2'(i),0,0,0,1,0));
        for (int i = 0; i < 8; i++) add(1,0,1,0,0, mko(0,1,0,0,1,3'(i),0,1,0));
        add(1,0,0,0,0, mko(0,0,0,0,0,0,1,1,0));
        add(1,1,1,0,1, mko(0,0,0,0,0,0,1,1,0));
        add(1,0,0,1,1, mko(0,0,0,0,0,0,1,1,0));
`ifdef FILTER_REUSE_EN
        add(1,0,0,0,1, mko(0,1,0,0,0,0,0,1,1));
`else
        add(1,0,0,0,1, mko(1,0,0,0,0,0,0,1,1));
`endif

        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();

        foreach (tbl[i]) begin
            drive(tbl[i].se, tbl[i].vf, tbl[i].vx, tbl[i].cd, tbl[i].ru);
            chk($sformatf("vec%0d", i), 32'(cur()), 32'(tbl[i].o));
            tick();
        end

        // Gapped X valids with a spurious conv_done during the load
        do_reset();
        drive(1, 0, 0, 0, 0);
        tick();
        load_f_full(0, "gap");
        wr_seen = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 1'(i % 2), (i == 4 || i == 7), 0);
            chk("gap_xwe", 32'(xmem_wr_en), 32'(i % 2));
            chk("gap_xaddr", 32'(xmem_wr_addr), 32'(i / 2));
            chk("gap_ready", 32'({s_ready_x, conv_start, conv_count}), 32'({1'b1, 1'b0, 16'd0}));
            if (xmem_wr_en) wr_seen++;
            tick();
        end
        chk("gap_writes", 32'(wr_seen), 32'd8);

        // seq_en low at conv_done returns to IDLE; re-enable restarts filter at address 0
        drive(0, 0, 0, 1, 0);
        chk("stop_conv", 32'(cur()), 32'(mko(0,0,0,0,0,0,1,1,0)));
        tick();
        drive(0, 0, 0, 0, 0);
        chk("stop_idle", 32'(cur()), 32'(mko(0,0,0,0,0,0,0,0,1)));
        tick();
        drive(0, 1, 1, 0, 0);
        chk("stop_hold", 32'(cur()), 32'(mko(0,0,0,0,0,0,0,0,1)));
        tick();
        drive(1, 0, 0, 0, 0);
        tick();
        load_f_full(1, "restart");

        // Reset in the middle of LOAD_X at x_cnt=5
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 0, 0);
            tick();
        end
        drive(1, 0, 1, 0, 0);
        chk("mid_x_addr", 32'({xmem_wr_en, xmem_wr_addr}), 32'({1'b1, 3'd5}));
        reset = 1'b1;
        tick();
        drive(1, 1, 1, 0, 0);
        chk("mid_reset", 32'(cur()), 32'(mko(0,0,0,0,0,0,0,0,0)));
        reset = 1'b0;
        tick();
        load_f_full(0, "post_reset");
        drive(1, 0, 1, 0, 0);
        chk("post_reset_x0", 32'({s_ready_x, xmem_wr_en, xmem_wr_addr}), 32'({1'b1, 1'b1, 3'd0}));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
